// File: rtl/bcd_time_keeper_pkg.sv
// Shared time-of-day constants and the BCD range check used when validating a time-set.
package time_defs;

  localparam logic [7:0] SEC_MAX  = 8'h59;
  localparam logic [7:0] MIN_MAX  = 8'h59;
  localparam logic [7:0] HOUR_MAX = 8'h23;
  localparam logic [7:0] BCD_ZERO = 8'h00;

  // With both digits <= 9, packed BCD orders like its decimal value, so a plain compare bounds the range.
  function automatic logic is_valid_bcd(input logic [7:0] value, input logic [7:0] max);
    return (value[3:0] <= 4'd9) && (value[7:4] <= 4'd9) && (value <= max);
  endfunction

endpackage

// File: rtl/bcd_time_keeper_field_inc.sv
// Combinational increment of one packed-BCD time field, wrapping at max and reporting a carry.
module bcd_field_inc
  import time_defs::*;
(
  input  logic [7:0] in,
  input  logic [7:0] max,
  input  logic       en,
  output logic [7:0] out,
  output logic       carry
);

  always_comb begin
    out   = in;
    carry = 1'b0;
    if (en) begin
      if (in == max) begin
        out   = BCD_ZERO;
        carry = 1'b1;
      end else if (in[3:0] == 4'd9) begin
        out = {in[7:4] + 4'd1, 4'd0};
      end else begin
        out = {in[7:4], in[3:0] + 4'd1};
      end
    end
  end

endmodule

// File: rtl/bcd_time_keeper.sv
// 24 h BCD time-of-day register with a one-second prescaler, carry chain and validated time-set.
module bcd_time_keeper
  import time_defs::*;
#(
  parameter int unsigned CLK_DIV = 100_000_000,
  parameter int unsigned DIV_W   = 27
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       run,
  input  logic       load,
  input  logic [7:0] set_hour,
  input  logic [7:0] set_min,
  input  logic [7:0] set_sec,
  output logic [7:0] hour,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       sec_tick,
  output logic       min_wrap,
  output logic       day_wrap,
  output logic       load_err
);

  localparam logic [DIV_W-1:0] CNT_LAST = DIV_W'(CLK_DIV - 1);

  logic [DIV_W-1:0] cnt_q, cnt_d;
  logic [7:0]       hour_q, hour_d, min_q, min_d, sec_q, sec_d;
  logic             sec_tick_q, sec_tick_d, min_wrap_q, min_wrap_d;
  logic             day_wrap_q, day_wrap_d, load_err_q, load_err_d;

  logic       tick, load_ok;
  logic [7:0] sec_nxt, min_nxt, hour_nxt;
  logic       sec_carry, min_carry, hour_carry;

  assign tick    = run && (cnt_q == CNT_LAST);
  assign load_ok = load && is_valid_bcd(set_hour, HOUR_MAX)
                        && is_valid_bcd(set_min, MIN_MAX)
                        && is_valid_bcd(set_sec, SEC_MAX);

  bcd_field_inc u_sec_inc (
    .in(sec_q), .max(SEC_MAX), .en(tick), .out(sec_nxt), .carry(sec_carry)
  );

  bcd_field_inc u_min_inc (
    .in(min_q), .max(MIN_MAX), .en(sec_carry), .out(min_nxt), .carry(min_carry)
  );

  bcd_field_inc u_hour_inc (
    .in(hour_q), .max(HOUR_MAX), .en(min_carry), .out(hour_nxt), .carry(hour_carry)
  );

  always_comb begin
    cnt_d      = cnt_q;
    hour_d     = hour_q;
    min_d      = min_q;
    sec_d      = sec_q;
    sec_tick_d = 1'b0;
    min_wrap_d = 1'b0;
    day_wrap_d = 1'b0;
    load_err_d = 1'b0;
    // A valid load overrides a coincident tick; a rejected load lets the tick through.
    if (load_ok) begin
      cnt_d  = '0;
      hour_d = set_hour;
      min_d  = set_min;
      sec_d  = set_sec;
    end else begin
      load_err_d = load;
      if (run) begin
        cnt_d = tick ? '0 : cnt_q + DIV_W'(1);
      end
      if (tick) begin
        sec_d      = sec_nxt;
        min_d      = min_nxt;
        hour_d     = hour_nxt;
        sec_tick_d = 1'b1;
        min_wrap_d = sec_carry;
        day_wrap_d = hour_carry;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q      <= '0;
      hour_q     <= BCD_ZERO;
      min_q      <= BCD_ZERO;
      sec_q      <= BCD_ZERO;
      sec_tick_q <= 1'b0;
      min_wrap_q <= 1'b0;
      day_wrap_q <= 1'b0;
      load_err_q <= 1'b0;
    end else begin
      cnt_q      <= cnt_d;
      hour_q     <= hour_d;
      min_q      <= min_d;
      sec_q      <= sec_d;
      sec_tick_q <= sec_tick_d;
      min_wrap_q <= min_wrap_d;
      day_wrap_q <= day_wrap_d;
      load_err_q <= load_err_d;
    end
  end

  assign hour     = hour_q;
  assign min      = min_q;
  assign sec      = sec_q;
  assign sec_tick = sec_tick_q;
  assign min_wrap = min_wrap_q;
  assign day_wrap = day_wrap_q;
  assign load_err = load_err_q;

endmodule

// File: tb/tb_bcd_time_keeper.sv
// Bench for bcd_time_keeper: directed vector table, corner sequences, and random traffic against a seconds-of-day model.
module tb_bcd_time_keeper;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       run, load;
  logic [7:0] set_hour, set_min, set_sec;
  logic [7:0] hour, min, sec;
  logic       sec_tick, min_wrap, day_wrap, load_err;

  int checks = 0;
  int errors = 0;

  // Reference model: time as seconds since midnight, prescaler as a plain count.
  int   m_tod, m_cnt;
  logic m_tick, m_mw, m_dw, m_err;

  typedef struct {
    logic       run, load;
    logic [7:0] h, m, s;
    logic [7:0] eh, em, es;
    logic       et, emw, edw, eerr;
  } vec_t;

  vec_t tbl[26];

  bcd_time_keeper #(.CLK_DIV(DIV), .DIV_W(27)) dut (
    .clk(clk), .rst_n(rst_n), .run(run), .load(load),
    .set_hour(set_hour), .set_min(set_min), .set_sec(set_sec),
    .hour(hour), .min(min), .sec(sec),
    .sec_tick(sec_tick), .min_wrap(min_wrap), .day_wrap(day_wrap), .load_err(load_err)
  );

  always #5 clk = ~clk;

  function automatic int bcd2int(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  function automatic logic [7:0] int2bcd(input int v);
    return {4'(v / 10), 4'(v % 10)};
  endfunction

  function automatic logic digits_ok(input logic [7:0] b);
    return (b[7:4] <= 4'd9) && (b[3:0] <= 4'd9);
  endfunction

  function automatic logic set_ok(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    return digits_ok(h) && digits_ok(m) && digits_ok(s) &&
           bcd2int(h) < 24 && bcd2int(m) < 60 && bcd2int(s) < 60;
  endfunction

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_tod = 0; m_cnt = 0; m_tick = 0; m_mw = 0; m_dw = 0; m_err = 0;
  endtask

  task automatic model_step(input logic r, input logic ld, input logic [7:0] h,
                            input logic [7:0] m, input logic [7:0] s);
    logic tk, ok;
    tk     = r && (m_cnt == DIV - 1);
    ok     = ld && set_ok(h, m, s);
    m_tick = tk && !ok;
    m_mw   = m_tick && (m_tod % 60 == 59);
    m_dw   = m_tick && (m_tod == 86399);
    m_err  = ld && !ok;
    if (ok) begin
      m_tod = bcd2int(h) * 3600 + bcd2int(m) * 60 + bcd2int(s);
      m_cnt = 0;
    end else begin
      if (r) m_cnt = (m_cnt + 1) % DIV;
      if (tk) m_tod = (m_tod + 1) % 86400;
    end
  endtask

  task automatic check_model();
    check("m_hour", hour, int2bcd(m_tod / 3600));
    check("m_min", min, int2bcd((m_tod / 60) % 60));
    check("m_sec", sec, int2bcd(m_tod % 60));
    check("m_sec_tick", {7'd0, sec_tick}, {7'd0, m_tick});
    check("m_min_wrap", {7'd0, min_wrap}, {7'd0, m_mw});
    check("m_day_wrap", {7'd0, day_wrap}, {7'd0, m_dw});
    check("m_load_err", {7'd0, load_err}, {7'd0, m_err});
  endtask

  // One clock: drive at the falling edge, advance the model at the rising edge, sample 1 ns later.
  task automatic step(input logic r, input logic ld, input logic [7:0] h,
                      input logic [7:0] m, input logic [7:0] s);
    @(negedge clk);
    run = r; load = ld; set_hour = h; set_min = m; set_sec = s;
    @(posedge clk);
    model_step(r, ld, h, m, s);
    #1;
    check_model();
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_hour"}, hour, 8'h00);
    check({tag, "_min"}, min, 8'h00);
    check({tag, "_sec"}, sec, 8'h00);
    check({tag, "_pulses"}, {4'd0, sec_tick, min_wrap, day_wrap, load_err}, 8'h00);
  endtask

  initial begin
    int ticks;
    rst_n = 1'b0; run = 1'b0; load = 1'b0;
    set_hour = 8'h00; set_min = 8'h00; set_sec = 8'h00;
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_zero("reset");
    rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      logic [7:0] es;
      es = 8'((i + 1) / 4);
      tbl[i] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, es,
                 ((i % 4) == 3), 1'b0, 1'b0, 1'b0};
    end
    tbl[12] = '{1'b0, 1'b1, 8'h23, 8'h59, 8'h59, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[13] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h23, 8'h59, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[14] = tbl[13];
    tbl[15] = tbl[13];
    tbl[16] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 1'b1, 1'b1, 1'b1, 1'b0};
    tbl[17] = '{1'b0, 1'b1, 8'h12, 8'h34, 8'h09, 8'h12, 8'h34, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[18] = '{1'b0, 1'b1, 8'h24, 8'h00, 8'h00, 8'h12, 8'h34, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[19] = '{1'b0, 1'b1, 8'h00, 8'h00, 8'h5A, 8'h12, 8'h34, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[20] = '{1'b0, 1'b1, 8'h00, 8'h60, 8'h00, 8'h12, 8'h34, 8'h09, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[21] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0};
    tbl[22] = tbl[21];
    tbl[23] = tbl[21];
    tbl[24] = '{1'b1, 1'b0, 8'h00, 8'h00, 8'h00, 8'h12, 8'h34, 8'h10, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[25] = '{1'b1, 1'b1, 8'h1A, 8'h00, 8'h00, 8'h12, 8'h34, 8'h10, 1'b0, 1'b0, 1'b0, 1'b1};

    foreach (tbl[i]) begin
      step(tbl[i].run, tbl[i].load, tbl[i].h, tbl[i].m, tbl[i].s);
      check($sformatf("tbl%0d_hour", i), hour, tbl[i].eh);
      check($sformatf("tbl%0d_min", i), min, tbl[i].em);
      check($sformatf("tbl%0d_sec", i), sec, tbl[i].es);
      check($sformatf("tbl%0d_pulses", i), {4'd0, sec_tick, min_wrap, day_wrap, load_err},
            {4'd0, tbl[i].et, tbl[i].emw, tbl[i].edw, tbl[i].eerr});
    end

    // Asynchronous reset mid-count clears outputs before the next rising edge.
    step(1, 0, 8'h00, 8'h00, 8'h00);
    @(negedge clk);
    run = 1'b0;
    #2 rst_n = 1'b0;
    #1 check_zero("async_rst");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;

    // Pause with two counts done: ten frozen cycles, then the tick after the remaining two.
    step(1, 0, 8'h00, 8'h00, 8'h00);
    step(1, 0, 8'h00, 8'h00, 8'h00);
    ticks = 0;
    for (int i = 0; i < 10; i++) begin
      step(0, 0, 8'h00, 8'h00, 8'h00);
      ticks += int'(sec_tick);
    end
    check("pause_ticks", 8'(ticks), 8'd0);
    ticks = 0;
    for (int i = 0; i < 8 && !sec_tick; i++) begin
      step(1, 0, 8'h00, 8'h00, 8'h00);
      ticks++;
    end
    check("resume_cycles", 8'(ticks), 8'd2);
    check("resume_sec", sec, 8'h01);

    // Valid load exactly on the tick cycle swallows that tick.
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 8'h00, 8'h00);
    step(1, 1, 8'h08, 8'h15, 8'h30);
    check("load_tick_sec", sec, 8'h30);
    check("load_tick_pulse", {7'd0, sec_tick}, 8'd0);
    for (int i = 0; i < 4; i++) step(1, 0, 8'h00, 8'h00, 8'h00);
    check("after_load_sec", sec, 8'h31);
    check("after_load_pulse", {7'd0, sec_tick}, 8'd1);

    // Rejected load on the tick cycle still lets the tick through.
    for (int i = 0; i < 3; i++) step(1, 0, 8'h00, 8'h00, 8'h00);
    step(1, 1, 8'h99, 8'h00, 8'h00);
    check("bad_load_tick_err", {7'd0, load_err}, 8'd1);
    check("bad_load_tick_pulse", {7'd0, sec_tick}, 8'd1);
    check("bad_load_tick_sec", sec, 8'h32);

    for (int n = 0; n < 3000; n++) begin
      logic       r, ld;
      logic [7:0] h, m, s;
      int         kind;
      r    = ($urandom_range(0, 9) != 0);
      ld   = ($urandom_range(0, 11) == 0);
      kind = $urandom_range(0, 3);
      if (kind == 0) begin
        h = 8'($urandom); m = 8'($urandom); s = 8'($urandom);
      end else if (kind == 1) begin
        h = 8'h23; m = 8'h59; s = int2bcd($urandom_range(50, 59));
      end else begin
        h = int2bcd($urandom_range(0, 23));
        m = int2bcd($urandom_range(0, 59));
        s = int2bcd($urandom_range(0, 59));
      end
      step(r, ld, h, m, s);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
